// File: rtl/traffic_pkg.sv
// Shared types and sizing helper for the intersection controller.
// The optional walk preemption is enabled by defining TRAFFIC_WALK_PREEMPT_EN.
package traffic_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_GREEN  = 2'd1,
    LIGHT_YELLOW = 2'd2
  } light_e;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_WALK    = 2'd3
  } phase_e;

  // Counter must hold (longest duration - 1); one spare bit keeps the math unsigned-safe.
  function automatic int timer_width(input int green_t, input int yellow_t,
                                     input int allred_t, input int walk_t);
    int longest;
    longest = green_t;
    if (yellow_t > longest) longest = yellow_t;
    if (allred_t > longest) longest = allred_t;
    if (walk_t > longest) longest = walk_t;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// Loadable down-counter that times each phase of the intersection controller.
// Part of traffic_intersection_ctrl (optional feature macro: TRAFFIC_WALK_PREEMPT_EN).
module phase_timer #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Round-robin intersection controller with latched pedestrian requests served in an all-red WALK.
// Define TRAFFIC_WALK_PREEMPT_EN to let a pending request truncate GREEN once MIN_GREEN has elapsed.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR     = 2,
  parameter int GREEN_TIME  = 8,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 4,
  parameter int MIN_GREEN   = 3
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       walk_i,
  output logic [2*NUM_DIR-1:0]       signal_o,
  output logic                       walk_o,
  output logic                       walk_pending_o,
  output logic [$clog2(NUM_DIR)-1:0] active_dir_o,
  output logic [1:0]                 phase_o
);

  localparam int DW = $clog2(NUM_DIR);
  localparam int TW = timer_width(GREEN_TIME, YELLOW_TIME, ALLRED_TIME, WALK_TIME);

  localparam logic [DW-1:0] LAST_DIR = DW'(NUM_DIR - 1);
  localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_TIME - 1);
  localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_TIME - 1);
  localparam logic [TW-1:0] WALK_LD   = TW'(WALK_TIME - 1);

  phase_e               state, next_state;
  logic [DW-1:0]        next_dir, green_dir;
  logic                 first_green, next_first;
  logic                 next_pending;
  logic                 load;
  logic [TW-1:0]        load_val, timer_count;
  logic                 timer_zero;
  logic                 preempt;
  logic [2*NUM_DIR-1:0] next_signal;

  phase_timer #(
    .WIDTH    (TW),
    .RESET_VAL(ALLRED_LD)
  ) u_timer (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .load    (load),
    .load_val(load_val),
    .count   (timer_count),
    .zero    (timer_zero)
  );

`ifdef TRAFFIC_WALK_PREEMPT_EN
  // Timer value at which MIN_GREEN cycles of green have been shown (counting the current one).
  localparam logic [TW-1:0] PREEMPT_AT = TW'(GREEN_TIME - MIN_GREEN);
  assign preempt = walk_pending_o && (timer_count <= PREEMPT_AT);
`else
  assign preempt = 1'b0;
`endif

  assign green_dir = (first_green || active_dir_o == LAST_DIR) ? '0 : active_dir_o + DW'(1);
  assign phase_o   = state;

  always_comb begin
    next_state   = state;
    next_dir     = active_dir_o;
    next_first   = first_green;
    load         = 1'b0;
    load_val     = '0;
    next_pending = walk_pending_o | (walk_i && state != PH_WALK);
    case (state)
      PH_GREEN: begin
        if (timer_zero || preempt) begin
          next_state = PH_YELLOW;
          load       = 1'b1;
          load_val   = YELLOW_LD;
        end
      end
      PH_YELLOW: begin
        if (timer_zero) begin
          next_state = PH_ALL_RED;
          load       = 1'b1;
          load_val   = ALLRED_LD;
        end
      end
      PH_ALL_RED: begin
        if (timer_zero) begin
          load = 1'b1;
          if (walk_pending_o || walk_i) begin
            // Entering WALK serves the request; a same-cycle walk_i is absorbed too.
            next_state   = PH_WALK;
            load_val     = WALK_LD;
            next_pending = 1'b0;
          end else begin
            next_state = PH_GREEN;
            next_dir   = green_dir;
            next_first = 1'b0;
            load_val   = GREEN_LD;
          end
        end
      end
      PH_WALK: begin
        if (timer_zero) begin
          next_state = PH_GREEN;
          next_dir   = green_dir;
          next_first = 1'b0;
          load       = 1'b1;
          load_val   = GREEN_LD;
        end
      end
      default: begin
        next_state = PH_ALL_RED;
        load       = 1'b1;
        load_val   = ALLRED_LD;
      end
    endcase
  end

  // Lamps are decoded from the next state so the registered outputs line up with the phase.
  always_comb begin
    next_signal = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      if (DW'(d) == next_dir) begin
        if (next_state == PH_GREEN) begin
          next_signal[2*d +: 2] = LIGHT_GREEN;
        end else if (next_state == PH_YELLOW) begin
          next_signal[2*d +: 2] = LIGHT_YELLOW;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= PH_ALL_RED;
      active_dir_o   <= '0;
      first_green    <= 1'b1;
      walk_pending_o <= 1'b0;
      signal_o       <= '0;
      walk_o         <= 1'b0;
    end else begin
      state          <= next_state;
      active_dir_o   <= next_dir;
      first_green    <= next_first;
      walk_pending_o <= next_pending;
      signal_o       <= next_signal;
      walk_o         <= (next_state == PH_WALK);
    end
  end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed-plus-random bench for traffic_intersection_ctrl against a cycle-counting phase model.
// Honours TRAFFIC_WALK_PREEMPT_EN in the model when the macro is defined.
`timescale 1ns/1ps
module tb_traffic_intersection_ctrl;

  localparam int NUM_DIR     = 2;
  localparam int GREEN_TIME  = 8;
  localparam int YELLOW_TIME = 2;
  localparam int ALLRED_TIME = 1;
  localparam int WALK_TIME   = 4;
  localparam int MIN_GREEN   = 3;
  localparam int DW          = $clog2(NUM_DIR);

  localparam int M_ALLRED = 0;
  localparam int M_GREEN  = 1;
  localparam int M_YELLOW = 2;
  localparam int M_WALK   = 3;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 walk_i = 1'b0;
  logic [2*NUM_DIR-1:0] signal_o;
  logic                 walk_o;
  logic                 walk_pending_o;
  logic [DW-1:0]        active_dir_o;
  logic [1:0]           phase_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: which phase, how many cycles already spent in it, who is served, request latch.
  int m_phase, m_elapsed, m_dir;
  bit m_first, m_pending;

  traffic_intersection_ctrl #(
    .NUM_DIR    (NUM_DIR),
    .GREEN_TIME (GREEN_TIME),
    .YELLOW_TIME(YELLOW_TIME),
    .ALLRED_TIME(ALLRED_TIME),
    .WALK_TIME  (WALK_TIME),
    .MIN_GREEN  (MIN_GREEN)
  ) dut (
    .clk           (clk),
    .rst_ni        (rst_ni),
    .walk_i        (walk_i),
    .signal_o      (signal_o),
    .walk_o        (walk_o),
    .walk_pending_o(walk_pending_o),
    .active_dir_o  (active_dir_o),
    .phase_o       (phase_dbg)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int ph);
    case (ph)
      M_GREEN:  return GREEN_TIME;
      M_YELLOW: return YELLOW_TIME;
      M_WALK:   return WALK_TIME;
      default:  return ALLRED_TIME;
    endcase
  endfunction

  task automatic model_reset();
    m_phase   = M_ALLRED;
    m_elapsed = 0;
    m_dir     = 0;
    m_first   = 1'b1;
    m_pending = 1'b0;
  endtask

  task automatic go_green();
    m_dir   = m_first ? 0 : (m_dir + 1) % NUM_DIR;
    m_first = 1'b0;
    m_phase = M_GREEN;
  endtask

  task automatic model_step(input logic w);
    bit expire, set_req, into_walk;
    into_walk = 1'b0;
    set_req   = w && (m_phase != M_WALK);
    expire    = (m_elapsed + 1 >= dur(m_phase));
`ifdef TRAFFIC_WALK_PREEMPT_EN
    if (m_phase == M_GREEN && m_pending && m_elapsed + 1 >= MIN_GREEN) expire = 1'b1;
`endif
    if (expire) begin
      m_elapsed = 0;
      case (m_phase)
        M_GREEN:  m_phase = M_YELLOW;
        M_YELLOW: m_phase = M_ALLRED;
        M_ALLRED: begin
          if (m_pending || w) begin
            m_phase   = M_WALK;
            into_walk = 1'b1;
          end else begin
            go_green();
          end
        end
        default:  go_green();
      endcase
    end else begin
      m_elapsed++;
    end
    if (into_walk) m_pending = 1'b0;
    else if (set_req) m_pending = 1'b1;
  endtask

  function automatic logic [2*NUM_DIR-1:0] exp_signal();
    logic [2*NUM_DIR-1:0] v;
    v = '0;
    if (m_phase == M_GREEN)  v[2*m_dir +: 2] = 2'd1;
    if (m_phase == M_YELLOW) v[2*m_dir +: 2] = 2'd2;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    int nonred;
    nonred = 0;
    for (int d = 0; d < NUM_DIR; d++) if (signal_o[2*d +: 2] != 2'd0) nonred++;
    check({ctx, ".signal"}, 32'(signal_o), 32'(exp_signal()));
    check({ctx, ".walk"}, 32'(walk_o), 32'(m_phase == M_WALK));
    check({ctx, ".pending"}, 32'(walk_pending_o), 32'(m_pending));
    check({ctx, ".dir"}, 32'(active_dir_o), 32'(m_dir));
    check({ctx, ".one_lit"}, 32'(nonred <= 1), 32'd1);
  endtask

  task automatic step(input logic w, input string ctx);
    walk_i = w;
    @(posedge clk);
    model_step(w);
    @(negedge clk);
    check_all(ctx);
  endtask

  initial begin
    int g;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_ni = 1'b1;

    // Free-running rotation, no pedestrians: more than two full periods.
    repeat (50) step(1'b0, "rotate");

    // One-cycle request on the first cycle of a dir0 green.
    for (g = 0; g < 60 && !(m_phase == M_GREEN && m_dir == 0 && m_elapsed == 0); g++)
      step(1'b0, "seek_g0");
    check("locate_g0", 32'(m_phase == M_GREEN && m_dir == 0), 32'd1);
    step(1'b1, "pulse");
    repeat (20) step(1'b0, "walk_serve");

    // Request only at ALL_RED expiry, then held through the whole WALK.
    for (g = 0; g < 60 && !(m_phase == M_ALLRED && !m_pending); g++)
      step(1'b0, "seek_ar");
    check("locate_ar", 32'(m_phase == M_ALLRED && !m_pending), 32'd1);
    repeat (1 + WALK_TIME) step(1'b1, "walk_hold");
    repeat (25) step(1'b0, "after_hold");

    // Sparse random requests.
    repeat (300) step(($urandom_range(0, 9) == 0), "random");

    // Asynchronous reset during dir1 YELLOW with a request latched.
    for (g = 0; g < 60 && !(m_phase == M_GREEN && m_dir == 1); g++)
      step(1'b0, "seek_g1");
    step(1'b1, "req_g1");
    for (g = 0; g < 60 && !(m_phase == M_YELLOW && m_dir == 1); g++)
      step(1'b0, "seek_y1");
    check("locate_y1", 32'(m_phase == M_YELLOW && m_dir == 1 && m_pending), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_all("rst_held");
    rst_ni = 1'b1;
    repeat (30) step(1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
Parametrised multi-approach intersection controller. It sequences NUM_DIR vehicle approaches round-robin through GREEN, YELLOW and ALL_RED, with programmable phase durations. Pedestrian requests are latched and served in a dedicated all-red WALK phase. It is the next-generation replacement for the single-signal red/green/yellow controller, and sits between the pedestrian push-button synchroniser and the lamp drivers.

Parameters:
NUM_DIR, 2, number of vehicle approaches (2..8)
GREEN_TIME, 8, cycles per GREEN phase (>=1)
YELLOW_TIME, 2, cycles per YELLOW phase (>=1)
ALLRED_TIME, 1, cycles of all-red clearance after each YELLOW (>=1)
WALK_TIME, 4, cycles of the WALK phase (>=1)
MIN_GREEN, 3, minimum green before preemption (1..GREEN_TIME); used only with the optional feature

Ports:
clk  input  1  clock
rst_ni  input  1  asynchronous active-low reset
walk_i  input  1  pedestrian request, synchronous level/pulse, sampled every cycle
signal_o  output  2*NUM_DIR  per-approach light, slice [2d+1:2d]; RED=0, GREEN=1, YELLOW=2
walk_o  output  1  pedestrian walk lamp, high only in WALK
walk_pending_o  output  1  latched request not yet served
active_dir_o  output  max(1,$clog2(NUM_DIR))  approach currently or last served

Behaviour:
- Reset (asynchronous, rst_ni=0): all signal_o slices RED; walk_o=0; walk_pending_o=0; active_dir_o=0; state ALL_RED; timer loaded with ALLRED_TIME-1; first-green flag set so that dir 0 receives the first green.
- Phases: the main FSM has states ALL_RED, GREEN, YELLOW and WALK. All outputs are registered, Moore-style, and derived from state and active_dir.
- Timer: a down-counter loaded with T-1 on entry to a phase of duration T. It decrements each cycle, and the state advances in the cycle the counter equals 0, so every phase lasts exactly T cycles. Counter width is $clog2(max time)+1.
- GREEN: signal_o[active_dir]=GREEN; all other slices RED. At expiry, go to YELLOW.
- YELLOW: signal_o[active_dir]=YELLOW; others RED. At expiry, go to ALL_RED.
- ALL_RED: all slices RED. At expiry:
  - if (walk_pending_o | walk_i), go to WALK;
  - else go to GREEN with active_dir = (active_dir+1) mod NUM_DIR, or dir 0 if the first-green flag is set (the flag is then cleared).
- WALK: all slices RED; walk_o=1. At expiry, go to GREEN on the next direction using the same rule as ALL_RED.
- Request latch:
  - set by walk_i in any state except WALK;
  - cleared on the ALL_RED→WALK transition; clear wins over a simultaneous set;
  - walk_i asserted while in WALK is dropped.
- Repeated walk_i while pending has no additional effect; at most one WALK is served per ALL_RED.
- No two approaches are ever simultaneously non-RED. An ALL_RED of at least ALLRED_TIME always precedes any GREEN, except the post-reset ALL_RED, which also counts.
- Mid-operation reset returns immediately to the reset values; a pending request is lost.
- Unused state encodings recover to ALL_RED with the timer loaded ALLRED_TIME-1.

Optional Feature:
Macro TRAFFIC_WALK_PREEMPT_EN.
- Defined: while in GREEN with walk_pending_o=1 and at least MIN_GREEN green cycles elapsed, go to YELLOW on the next edge (green is truncated, never below MIN_GREEN). A request arriving earlier preempts as soon as MIN_GREEN is reached.
- Not defined: GREEN always lasts GREEN_TIME; MIN_GREEN is unused; logic is identical to the base behaviour.

Decomposition:
- Package traffic_pkg holds:
  - light_e (2-bit: RED, GREEN, YELLOW);
  - phase_e (ALL_RED, GREEN, YELLOW, WALK);
  - a function returning the timer width from the duration parameters.
- One sub-module, phase_timer: a loadable down-counter with a load value input, a load strobe and a zero flag, parametrised on width, with the same clk/rst_ni.

Test Plan:
- Defaults, no walk_i, release reset: 1 ALL_RED cycle; dir0 GREEN for 8 cycles; YELLOW 2; ALL_RED 1; dir1 GREEN 8; YELLOW 2; ALL_RED 1; dir0 GREEN again. Period is 22 cycles, and signal_o never shows two non-RED slices.
- Pulse walk_i for 1 cycle during dir0 GREEN: walk_pending_o=1 next cycle. After YELLOW 2 and ALL_RED 1, WALK runs for 4 cycles with walk_o=1 and all RED, walk_pending_o drops on WALK entry, then dir1 GREEN.
- walk_i held high in the ALL_RED expiry cycle with no prior pending: WALK is entered. walk_i high throughout WALK: walk_pending_o stays 0 after WALK, and no second WALK occurs.
- NUM_DIR=3, GREEN_TIME=5, YELLOW_TIME=1, ALLRED_TIME=2: greens rotate 0→1→2→0, each 5 cycles, separated by 1 YELLOW and 2 ALL_RED; active_dir_o tracks the rotation.
- rst_ni dropped mid-YELLOW on dir1 with a request pending: all outputs reset asynchronously, before the next edge. After release, dir0 gets the first green and no WALK occurs.
- With TRAFFIC_WALK_PREEMPT_EN: walk_i on green cycle 1 gives YELLOW after green cycle 3 (MIN_GREEN). walk_i on green cycle 6 gives YELLOW on the next edge.
